// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot/multi-hot to index encoder.
package onehot_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/onehot_encoder_prio_enc.sv
// Combinational priority encoder: selects the lowest (or highest) set bit,
// returns its index and the vector with that bit cleared.
module prio_enc
  import onehot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             msb_first,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic [WIDTH-1:0] vec_clr,
  output logic             single
);

  always_comb begin
    idx     = '0;
    found   = 1'b0;
    vec_clr = vec;
    single  = 1'b0;
    // LSB-first keeps the first hit; MSB-first lets later hits overwrite.
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i] && (msb_first || !found)) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    if (found) begin
      vec_clr = vec & ~(WIDTH'(1) << idx);
    end
    single = found && ((vec & (vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/onehot_encoder.sv
// Serialises a captured vector into one index per beat (1 cycle to first beat),
// stalls on out_ready, in_ready low while emitting; ONEHOT_ENC_MSB_FIRST_EN flips order.
module onehot_encoder
  import onehot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic             out_onehot
);

`ifdef ONEHOT_ENC_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             zero_q, zero_d;
  logic             onehot_q, onehot_d;
  logic             in_ready_q, in_ready_d;

  logic [IDX_W-1:0] pe_idx;
  logic             pe_found;
  logic [WIDTH-1:0] pe_vec_clr;
  logic             pe_single;
  logic             pe_last;
  logic             in_single;

  prio_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec       (pend_q),
    .msb_first (MSB_FIRST),
    .idx       (pe_idx),
    .found     (pe_found),
    .vec_clr   (pe_vec_clr),
    .single    (pe_single)
  );

  assign pe_last   = pe_single || !pe_found;
  assign in_single = (in_vec != '0) && ((in_vec & (in_vec - WIDTH'(1))) == '0);

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    zero_d   = zero_q;
    onehot_d = onehot_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          pend_d   = in_vec;
          zero_d   = (in_vec == '0);
          onehot_d = in_single;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (pe_last) begin
            pend_d  = '0;
            state_d = IDLE;
          end else begin
            pend_d = pe_vec_clr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so in_ready stays low through reset and has no input path.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      zero_q     <= 1'b0;
      onehot_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      zero_q     <= zero_d;
      onehot_q   <= onehot_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q == EMIT);
  assign out_idx    = pe_idx;
  assign out_last   = out_valid && pe_last;
  assign out_zero   = out_valid && zero_q;
  assign out_onehot = out_valid && onehot_q;

endmodule

// File: tb/tb_onehot_encoder.sv
// Bench for onehot_encoder: vector table, stall/reset sequences, decoder
// round trip and randomised vectors against a set-bit list model.
module tb_onehot_encoder;

`ifdef ONEHOT_ENC_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_zero;
  logic       out_onehot;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [7:0] vec;
    int         beats;
    logic       zero;
    logic       onehot;
    int         first_lsb;
    int         first_msb;
  } vec_rec_t;

  vec_rec_t tbl[6];

  onehot_encoder #(.WIDTH(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_zero   (out_zero),
    .out_onehot (out_onehot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected index order: every set bit position, or a single 0 for an empty vector.
  task automatic build_exp(input logic [7:0] v);
    int tmp[$];
    exp_q.delete();
    for (int i = 0; i < 8; i++) if (v[i]) tmp.push_back(i);
    if (tmp.size() == 0) tmp.push_back(0);
    if (MSB) tmp.reverse();
    exp_q = tmp;
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    in_vec   = v;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("first_valid", out_valid, 1);
    chk("busy_rdy", in_ready, 0);
  endtask

  task automatic collect(input logic [7:0] v, input int prob, output int beats);
    int cyc = 0;
    build_exp(v);
    beats = 0;
    while (beats < exp_q.size() && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 99) < prob);
      if (out_valid && out_ready) begin
        chk("idx", out_idx, exp_q[beats]);
        chk("last", out_last, beats == exp_q.size() - 1);
        chk("zero", out_zero, v == 8'h00);
        chk("onehot", out_onehot, $countones(v) == 1);
        beats++;
      end
    end
    if (beats < exp_q.size()) chk("beat_timeout", beats, exp_q.size());
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_valid", out_valid, 0);
    chk("idle_rdy", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    logic [7:0] v;
    logic [7:0] oh;

    tbl[0] = '{8'b0000_0100, 1, 1'b0, 1'b1, 2, 2};
    tbl[1] = '{8'b1001_0010, 3, 1'b0, 1'b0, 1, 7};
    tbl[2] = '{8'h00,        1, 1'b1, 1'b0, 0, 0};
    tbl[3] = '{8'b1000_0000, 1, 1'b0, 1'b1, 7, 7};
    tbl[4] = '{8'hFF,        8, 1'b0, 1'b0, 0, 7};
    tbl[5] = '{8'h01,        1, 1'b0, 1'b1, 0, 0};

    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_onehot", out_onehot, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rdy_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", in_ready, 1);

    foreach (tbl[t]) begin
      send(tbl[t].vec);
      chk("tbl_first_idx", out_idx, MSB ? tbl[t].first_msb : tbl[t].first_lsb);
      chk("tbl_zero", out_zero, tbl[t].zero);
      chk("tbl_onehot", out_onehot, tbl[t].onehot);
      collect(tbl[t].vec, 100, beats);
      chk("tbl_beats", beats, tbl[t].beats);
    end

    // Stall with a competing input held high: it must not overwrite the pending vector.
    send(8'b1000_0000);
    out_ready = 1'b0;
    in_vec    = 8'h01;
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_idx", out_idx, 7);
      chk("stall_rdy", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    chk("stall_release_idx", out_idx, 7);
    chk("stall_release_last", out_last, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("stall_done_valid", out_valid, 0);
    send(8'h01);
    collect(8'h01, 100, beats);
    chk("stall_next_beats", beats, 1);

    // Asynchronous reset after three beats of 8'hFF.
    send(8'hFF);
    build_exp(8'hFF);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      out_ready = 1'b1;
      chk("pre_rst_idx", out_idx, exp_q[b]);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", in_ready, 1);
    send(8'h01);
    collect(8'h01, 100, beats);
    chk("post_rst_beats", beats, 1);

    // Round trip through an index-to-one-hot decoder.
    for (int idx = 0; idx < 8; idx++) begin
      oh = 8'h00;
      oh[idx] = 1'b1;
      send(oh);
      chk("rt_idx", out_idx, idx);
      chk("rt_onehot", out_onehot, 1);
      collect(oh, 100, beats);
    end

    for (int r = 0; r < 50; r++) begin
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1: begin v = 8'h00; v[$urandom_range(0, 7)] = 1'b1; end
        default: v = 8'($urandom);
      endcase
      send(v);
      collect(v, $urandom_range(25, 100), beats);
      chk("rand_beats", beats, ($countones(v) == 0) ? 1 : $countones(v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_encoder.md
Name: onehot_encoder

Overview:
- Reverse direction of the team's index-to-one-hot decoder: converts a WIDTH-bit vector back into bit indices.
- Accepts a vector over a valid/ready handshake and emits the index of every set bit, one index per output handshake, LSB first by default.
- Used wherever a one-hot or multi-hot select/grant vector must be turned back into binary indices, e.g. a decoder round-trip check, or serialising a multi-hot request mask.

Parameters:
- WIDTH, 8, input vector width (≥2).
- IDX_W, $clog2(WIDTH), index width (3 at default).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  WIDTH  vector to encode.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  downstream accepts the beat.
- out_idx  output  IDX_W  index of the current set bit.
- out_last  output  1  final beat for the current vector.
- out_zero  output  1  captured vector was all zeros (single dummy beat).
- out_onehot  output  1  captured vector had exactly one set bit.

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE, pend=0, flags=0.
  - out_valid=0, out_idx=0, out_last=0, out_zero=0, out_onehot=0.
  - in_ready=0 while rst is high; in_ready=1 from the first edge after rst releases.
- No combinational path from any input to any output; all outputs decode from registers.
- FSM states: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: pend<=in_vec; out_zero<=(in_vec==0); out_onehot<=(popcount==1); go to EMIT.
  - The vector is held in pend; in_vec is never re-sampled.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_idx = index of lowest set bit of pend, or 0 when pend==0.
  - out_last = (pend has ≤1 set bit).
  - out_idx, out_last, out_zero and out_onehot stay stable while out_valid&&!out_ready.
- On out_valid&&out_ready in EMIT:
  - If out_last: pend<=0 and go to IDLE.
  - Else: clear the lowest set bit of pend and stay in EMIT.
- Timing:
  - First out_valid appears in the cycle after input acceptance.
  - Beats per vector = max(1, popcount).
  - Minimum period per vector = beats + 1 cycles; back-to-back input acceptance is not allowed.
- Zero vector: exactly one beat with out_idx=0, out_zero=1, out_last=1.
- Bit WIDTH-1 set alone: out_idx=WIDTH-1, no overflow of IDX_W.
- in_valid held while in EMIT: ignored, not captured; the source must keep it asserted until in_ready.
- rst asserted mid-EMIT: the vector is discarded immediately and the block returns to IDLE with the reset values above.

Optional Feature:
- Macro ONEHOT_ENC_MSB_FIRST_EN.
- Defined:
  - Indices are emitted highest set bit first.
  - The cleared bit on each beat is the highest set bit.
  - Zero-vector and out_last rules are unchanged.
- Undefined: LSB-first order as above.
- Both builds share the identical port list.

Decomposition:
- Shared package onehot_pkg holds:
  - the state enum (IDLE, EMIT);
  - localparam DEF_WIDTH=8;
  - a function clog2-derived IDX_W helper.
- One natural sub-module: prio_enc, purely combinational.
  - Inputs: vector, direction select.
  - Outputs: index, found flag, vector-with-selected-bit-cleared, single-bit flag.
- The top level holds the FSM, pend register and handshake.

Test Plan:
- in_vec=8'b0000_0100, out_ready=1 → one beat: out_idx=2, out_last=1, out_onehot=1, out_zero=0; in_ready returns high the next cycle.
- in_vec=8'b1001_0010, out_ready=1 → three consecutive beats, idx 1, 4, 7, out_last only on 7; with ONEHOT_ENC_MSB_FIRST_EN, order is 7, 4, 1.
- in_vec=8'h00 → single beat: out_idx=0, out_zero=1, out_last=1.
- in_vec=8'b1000_0000 with out_ready held 0 for 5 cycles → out_valid=1 and out_idx=7 stable throughout; the beat completes when out_ready rises; a second in_valid during the stall is not accepted.
- Decoder round trip: loop idx 0..7 through the index-to-one-hot decoder into this block → each out_idx equals the source idx, and out_onehot=1 every time.
- in_vec=8'hFF, rst pulsed after 3 beats → out_valid drops asynchronously; after release, a new vector 8'h01 yields out_idx=0 with no residue.
